// File: rtl/approx_serial_sub_if.sv
// Handshake/data bundle for the bit-serial approximate subtractor.
// Latency: n/a (wires only); operand side and result side are independent valid/ready channels.
// Backpressure: in_ready gates operand acceptance, out_ready holds the result in place.
// Signals: in_valid/in_ready/a/b (operand channel), out_valid/out_ready/diff/bout (result
// channel), busy (engine running). master = producer/consumer side, slave = subtractor.
interface approx_serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );
endinterface

// File: rtl/approx_serial_sub.sv
// Bit-serial approximate subtractor (a - b, LSB first, borrow = ~a & b per cell).
// Latency: accept at edge E0 -> out_valid after edge E0+WIDTH; initiation interval >= WIDTH+2.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport of approx_serial_sub_if).
module approx_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_serial_sub_if.slave  bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IW-1:0]    i_q, i_d;
  logic             bin_q, bin_d;
  logic             bout_q, bout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    i_d     = i_q;
    bin_d   = bin_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          diff_d  = '0;
          i_d     = '0;
          bin_d   = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        diff_d[i_q] = a_q[i_q] ^ b_q[i_q] ^ bin_q;
        // Borrow-in is intentionally left out of the borrow term: this is the
        // approximation that keeps each cell independent of the chain.
        bin_d = ~a_q[i_q] & b_q[i_q];
        if (i_q == LAST_BIT) begin
          bout_d  = ~a_q[WIDTH-1] & b_q[WIDTH-1];
          state_d = S_DONE;
          // Index is left at the last bit; it is reloaded on the next accept.
        end else begin
          i_d = i_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next state decode, so they
    // depend only on the state register and never on in_valid/out_ready.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      i_q         <= '0;
      bin_q       <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      i_q         <= i_d;
      bin_q       <= bin_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule
